// File: rtl/pipe_pkg.sv
// Register-file constants and index type shared by the scoreboard, register file and forwarding logic.
// Registers CONST_LO and CONST_HI are hard-wired constants and never carry in-flight writes.
// Pure declarations: no latency and no flow control.
package pipe_pkg;

    localparam int NREG     = 8;
    localparam int AW       = 3;
    localparam int CNT_W    = 2;
    localparam int CONST_LO = 0;
    localparam int CONST_HI = 7;

    typedef logic [AW-1:0] reg_idx_t;

    function automatic logic is_tracked(input reg_idx_t r);
        return (r != reg_idx_t'(CONST_LO)) && (r != reg_idx_t'(CONST_HI));
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Counts in-flight writes to one register, with zero and at_max flags.
// Latency: the count updates on the clock edge and the flags follow it. The count saturates at both ends.
// Backpressure: the issuer must not inc at_max. A dec while the count is zero is ignored.
module sb_counter #(
    parameter int W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic at_max
);

    logic [W-1:0] cnt;
    logic         do_inc;
    logic         do_dec;

    assign zero   = (cnt == '0);
    assign at_max = &cnt;
    assign do_inc = inc && !at_max;
    assign do_dec = dec && !zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (do_inc && !do_dec) begin
            cnt <= cnt + 1'b1;
        end else if (do_dec && !do_inc) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order issue scoreboard: stalls on RAW hazards against in-flight writes and on counter overflow.
// Latency: stall is combinational from the registered counts. pend_mask follows an issue or writeback by 1 cycle.
// Backpressure: stall holds decode, and issue_accept = issue_valid && !stall.
module reg_scoreboard
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_ra,
    input  logic [AW-1:0]   issue_rb,
    input  logic            issue_uses_ra,
    input  logic            issue_uses_rb,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_writes_rd,
    output logic            stall,
    output logic            issue_accept,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    output logic [NREG-1:0] pend_mask,
    output logic            busy,
    output logic            wb_err
);

    logic [NREG-1:0] zero;
    logic [NREG-1:0] at_max;
    logic            raw_a;
    logic            raw_b;
    logic            ovf;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i != CONST_LO && i != CONST_HI) begin : g_trk
            logic inc;
            logic dec;
            assign inc = issue_accept && issue_writes_rd && (issue_rd == AW'(i));
            assign dec = wb_valid && (wb_rd == AW'(i));
            sb_counter #(.W(CNT_W)) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .inc    (inc),
                .dec    (dec),
                .zero   (zero[i]),
                .at_max (at_max[i])
            );
        end else begin : g_const
            assign zero[i]   = 1'b1;
            assign at_max[i] = 1'b0;
        end
    end

    // Only the registered counts are used here. A writeback in this cycle releases the reader in the next cycle,
    // when the register file has committed the value.
    always_comb begin
        raw_a        = issue_uses_ra && is_tracked(issue_ra) && !zero[issue_ra];
        raw_b        = issue_uses_rb && is_tracked(issue_rb) && !zero[issue_rb];
        ovf          = issue_writes_rd && is_tracked(issue_rd) && at_max[issue_rd];
        stall        = issue_valid && (raw_a || raw_b || ovf);
        issue_accept = issue_valid && !stall;
    end

    assign pend_mask = ~zero;
    assign busy      = |pend_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (wb_valid && is_tracked(wb_rd) && zero[wb_rd]) begin
            wb_err <= 1'b1;
        end
    end

endmodule
